jk_run_controller: RTL and testbench
====================================

JK_RUN_CONTROLLER -- requirements
Module: jk_run_controller

Interface
REQ-001 Parameter WIDTH, default 4; counter width in bits (2..8).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; one clock domain only.
REQ-004 start  input  1  run request; sampled only in IDLE.
REQ-005 abort  input  1  terminates an active run; sampled only in RUN.
REQ-006 mode  input  2  00 up, 01 down, 10 load, 11 hold; latched on start.
REQ-007 load_val  input  WIDTH  load value; latched on start.
REQ-008 run_len  input  WIDTH  number of count steps; latched on start.
REQ-009 q  output  WIDTH  current value of the JK register.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  one-cycle completion pulse.

Function
REQ-012 The block SHALL hold a WIDTH-bit register of JK cells plus an FSM with states IDLE, RUN and DONE; the FSM SHALL drive J, K and enable for every cell.
REQ-013 IDLE: all cell enables low, q held; start=1 SHALL latch mode, load_val and run_len, load step counter = run_len, and go to RUN.
REQ-014 RUN: each cycle the cells SHALL be enabled with the J/K of the latched mode, and the step counter SHALL decrement; the step that brings it to 0 SHALL transition to DONE.
REQ-015 Up mode: bit i SHALL use J=K=1 iff all bits below i are 1 (bit 0 always toggles); 15->0 wrap for WIDTH=4.
REQ-016 Down mode: bit i SHALL use J=K=1 iff all bits below i are 0; 0->15 wrap for WIDTH=4.
REQ-017 Load mode: J=load_val[i], K=~load_val[i] for one step only; run_len SHALL be ignored and RUN lasts exactly 1 cycle.
REQ-018 Hold mode: J=K=0 for run_len cycles; q SHALL not change.
REQ-019 run_len=0 with mode up/down/hold: SHALL go IDLE->DONE directly, with no cell update.
REQ-020 DONE: done=1 and busy=0 for exactly one cycle, then IDLE; start in DONE SHALL be ignored.
REQ-021 Latency: start accepted at edge N -> first q update at edge N+1 -> last update at edge N+run_len -> done high during the following cycle.
REQ-022 start during RUN or DONE SHALL be ignored; latched values SHALL not change mid-run.
REQ-023 abort=1 in RUN SHALL disable the cells in that cycle (no update), go to IDLE and suppress done; abort in IDLE/DONE SHALL be ignored.
REQ-024 abort and last step in the same cycle: abort SHALL win (no update, no done).

Reset
REQ-025 reset low SHALL asynchronously force state IDLE, q=0, step counter=0, latched mode=00, busy=0 and done=0.
REQ-026 reset asserted mid-run SHALL discard the run; after release the block SHALL wait in IDLE for a new start.

Structure
REQ-027 A shared package SHALL hold the mode encodings (MODE_UP, MODE_DOWN, MODE_LOAD, MODE_HOLD) and the state encodings.
REQ-028 One sub-module, jk_cell, SHALL implement a single JK flip-flop with enable and asynchronous active-low reset (Q' = J&~Q | ~K&Q when enabled), instantiated WIDTH times.
REQ-029 All J/K excitation logic SHALL live in the controller, not in jk_cell.

Verification
REQ-030 Reset, start mode=up run_len=3 -> q 1,2,3 on successive edges; done pulses once the cycle after q=3; busy high exactly 3 cycles.
REQ-031 Reach q=1, then mode=down run_len=3 -> q 0,15,14; done pulses once.
REQ-032 From q=14, mode=load load_val=0xA run_len=7 -> q=0xA after 1 edge; done the next cycle; busy 1 cycle.
REQ-033 Up run_len=0 -> done in the cycle after start; q unchanged; busy never high.
REQ-034 Up run_len=8 from 0, abort after q=4 -> q stays 4, no done, IDLE; new start is then accepted.
REQ-035 Reset pulsed low mid-run at q=5 -> q=0 immediately, busy=0; start held during RUN has no effect.

Source files
------------

// File: rtl/jk_run_controller_pkg.sv
// Shared encodings for the JK run controller: counting modes, FSM states and width limits.
// Mode and state values are fixed so that reset values (MODE_UP, ST_IDLE) are all-zero.
package jk_run_controller_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_LOAD = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 8;

    // Load is a single fixed step; every other mode runs for run_len steps.
    function automatic logic mode_uses_len(input mode_e m);
        return (m != MODE_LOAD);
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with clock enable and asynchronous active-low reset.
// Holds its value whenever the enable is low; excitation is supplied from outside.
module jk_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_j,
    input  logic i_k,
    output logic o_q
);

    logic r_q;

    // JK characteristic equation, applied only on enabled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else if (i_en) begin
            r_q <= (i_j & ~r_q) | (~i_k & r_q);
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/jk_run_controller.sv
// Run controller driving a WIDTH-bit register of JK cells as an up/down/load/hold counter.
// A start in IDLE latches the run parameters; the FSM sequences RUN steps and a one-cycle DONE.
module jk_run_controller
    import jk_run_controller_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] run_len,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] STEP_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] STEP_ZERO = WIDTH'(0);

    state_e           r_state;
    state_e           w_state_next;
    mode_e            r_mode;
    mode_e            w_mode_next;
    mode_e            w_mode_in;
    logic [WIDTH-1:0] r_load_val;
    logic [WIDTH-1:0] w_load_val_next;
    logic [WIDTH-1:0] r_steps;
    logic [WIDTH-1:0] w_steps_next;
    logic             r_busy;
    logic             r_done;
    logic             w_cell_en;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_low_ones;
    logic [WIDTH-1:0] w_low_zeros;

    assign w_mode_in = mode_e'(mode);

    // Next-state, parameter latching and cell enable
    always_comb begin
        w_state_next    = r_state;
        w_mode_next     = r_mode;
        w_load_val_next = r_load_val;
        w_steps_next    = r_steps;
        w_cell_en       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_mode_next     = w_mode_in;
                    w_load_val_next = load_val;
                    if (!mode_uses_len(w_mode_in)) begin
                        w_steps_next = STEP_ONE;
                        w_state_next = ST_RUN;
                    end else if (run_len == STEP_ZERO) begin
                        w_steps_next = STEP_ZERO;
                        w_state_next = ST_DONE;
                    end else begin
                        w_steps_next = run_len;
                        w_state_next = ST_RUN;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // Abort beats the final step: no update and no done pulse
                    w_steps_next = STEP_ZERO;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cell_en    = 1'b1;
                    w_steps_next = r_steps - STEP_ONE;
                    if (r_steps == STEP_ONE) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Per-bit J/K excitation from the latched mode and the current register value
    always_comb begin
        w_low_ones     = '0;
        w_low_zeros    = '0;
        w_low_ones[0]  = 1'b1;
        w_low_zeros[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_low_ones[i]  = w_low_ones[i-1] & w_q[i-1];
            w_low_zeros[i] = w_low_zeros[i-1] & ~w_q[i-1];
        end
        w_j = '0;
        w_k = '0;
        case (r_mode)
            MODE_UP: begin
                w_j = w_low_ones;
                w_k = w_low_ones;
            end
            MODE_DOWN: begin
                w_j = w_low_zeros;
                w_k = w_low_zeros;
            end
            MODE_LOAD: begin
                w_j = r_load_val;
                w_k = ~r_load_val;
            end
            MODE_HOLD: begin
                w_j = '0;
                w_k = '0;
            end
            default: begin
                w_j = '0;
                w_k = '0;
            end
        endcase
    end

    // State, latched run parameters and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_mode     <= MODE_UP;
            r_load_val <= '0;
            r_steps    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_mode     <= w_mode_next;
            r_load_val <= w_load_val_next;
            r_steps    <= w_steps_next;
            r_busy     <= (w_state_next == ST_RUN);
            r_done     <= (w_state_next == ST_DONE);
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .rst_n (reset),
            .i_en  (w_cell_en),
            .i_j   (w_j[g]),
            .i_k   (w_k[g]),
            .o_q   (w_q[g])
        );
    end

    assign q    = w_q;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_jk_run_controller.sv
// Directed bench for jk_run_controller (WIDTH=4): up/down/load/hold runs, zero length,
// abort, start during RUN/DONE, and asynchronous reset mid-run.
module tb_jk_run_controller;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [1:0] mode;
    logic [3:0] load_val;
    logic [3:0] run_len;
    logic [3:0] q;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    jk_run_controller #(.WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .mode     (mode),
        .load_val (load_val),
        .run_len  (run_len),
        .q        (q),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge passes; inputs are driven and outputs sampled at the falling edge
    task automatic tick();
        @(negedge clk);
    endtask

    // Drive q to a known value via a load run and return to IDLE
    task automatic preload(input logic [3:0] v);
        start = 1'b1; mode = 2'b10; load_val = v; run_len = 4'd0;
        tick();
        start = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        checks++;
        if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: q=%0d busy=%b done=%b, required q=0 busy=0 done=0", q, busy, done);
        end
    endtask

    task automatic test_up();
        int busy_cnt;
        busy_cnt = 0;
        start = 1'b1; mode = 2'b00; run_len = 4'd3; load_val = 4'd0;
        tick();
        start = 1'b0;
        busy_cnt += int'(busy);
        checks++;
        if (q !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL up_accept: q=%0d busy=%b, required q=0 busy=1", q, busy);
        end
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) start = 1'b1;
            tick();
            busy_cnt += int'(busy);
            checks++;
            if (q !== 4'(k) || done !== (k == 3)) begin
                errors++;
                $display("FAIL up_step%0d: q=%0d done=%b, required q=%0d done=%b", k, q, done, k, (k == 3));
            end
        end
        // start was held high through the DONE cycle and must be ignored
        tick();
        start = 1'b0;
        busy_cnt += int'(busy);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== 4'd3) begin
            errors++;
            $display("FAIL up_after_done: q=%0d busy=%b done=%b, required q=3 busy=0 done=0", q, busy, done);
        end
        tick();
        busy_cnt += int'(busy);
        checks++;
        if (busy_cnt != 3) begin
            errors++;
            $display("FAIL up_busy_cycles: got %0d, required 3", busy_cnt);
        end
    endtask

    task automatic test_down();
        logic [3:0] exp_q [3];
        exp_q[0] = 4'd0; exp_q[1] = 4'd15; exp_q[2] = 4'd14;
        preload(4'd1);
        checks++;
        if (q !== 4'd1) begin
            errors++;
            $display("FAIL down_preload: q=%0d, required 1", q);
        end
        start = 1'b1; mode = 2'b01; run_len = 4'd3;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (q !== exp_q[k] || done !== (k == 2)) begin
                errors++;
                $display("FAIL down_step%0d: q=%0d done=%b, required q=%0d done=%b", k, q, done, exp_q[k], (k == 2));
            end
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL down_done_width: done=%b, required 0", done);
        end
    endtask

    task automatic test_load();
        start = 1'b1; mode = 2'b10; load_val = 4'hA; run_len = 4'd7;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || q !== 4'd14) begin
            errors++;
            $display("FAIL load_accept: q=%0d busy=%b, required q=14 busy=1", q, busy);
        end
        tick();
        checks++;
        if (q !== 4'hA || busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL load_result: q=%0d busy=%b done=%b, required q=10 busy=0 done=1", q, busy, done);
        end
        tick();
        checks++;
        if (q !== 4'hA || done !== 1'b0) begin
            errors++;
            $display("FAIL load_hold: q=%0d done=%b, required q=10 done=0", q, done);
        end
    endtask

    task automatic test_zero_len_and_hold();
        start = 1'b1; mode = 2'b00; run_len = 4'd0;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || q !== 4'hA) begin
            errors++;
            $display("FAIL zero_len: q=%0d busy=%b done=%b, required q=10 busy=0 done=1", q, busy, done);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== 4'hA) begin
            errors++;
            $display("FAIL zero_len_after: q=%0d busy=%b done=%b, required q=10 busy=0 done=0", q, busy, done);
        end
        start = 1'b1; mode = 2'b11; run_len = 4'd2;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (q !== 4'hA || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_mid: q=%0d busy=%b, required q=10 busy=1", q, busy);
        end
        tick();
        checks++;
        if (q !== 4'hA || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_end: q=%0d busy=%b done=%b, required q=10 busy=0 done=1", q, busy, done);
        end
        tick();
    endtask

    task automatic test_abort();
        int done_seen;
        done_seen = 0;
        preload(4'd0);
        start = 1'b1; mode = 2'b00; run_len = 4'd8;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (q !== 4'd4) begin
            errors++;
            $display("FAIL abort_pre: q=%0d, required 4", q);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (q !== 4'd4 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_cycle: q=%0d busy=%b done=%b, required q=4 busy=0 done=0", q, busy, done);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            done_seen += int'(done);
        end
        checks++;
        if (done_seen != 0 || q !== 4'd4) begin
            errors++;
            $display("FAIL abort_no_done: done pulses=%0d q=%0d, required 0 pulses q=4", done_seen, q);
        end
        start = 1'b1; mode = 2'b00; run_len = 4'd1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (q !== 4'd5 || done !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart: q=%0d done=%b, required q=5 done=1", q, done);
        end
        tick();
    endtask

    task automatic test_reset_midrun();
        preload(4'd3);
        start = 1'b1; mode = 2'b00; run_len = 4'd8;
        tick();
        tick();
        // start stays high and the inputs change while running
        mode = 2'b01; load_val = 4'd0; run_len = 4'd1;
        tick();
        checks++;
        if (q !== 4'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_latched: q=%0d busy=%b, required q=5 busy=1", q, busy);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: q=%0d busy=%b done=%b, required q=0 busy=0 done=0", q, busy, done);
        end
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: q=%0d busy=%b done=%b, required q=0 busy=0 done=0", q, busy, done);
        end
        start = 1'b1; mode = 2'b00; run_len = 4'd1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (q !== 4'd1 || done !== 1'b1) begin
            errors++;
            $display("FAIL reset_restart: q=%0d done=%b, required q=1 done=1", q, done);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        mode = 2'b00; load_val = 4'd0; run_len = 4'd0;
        tick();
        tick();
        test_reset();
        reset = 1'b1;
        tick();
        test_up();
        test_down();
        test_load();
        test_zero_len_and_hold();
        test_abort();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
